// File: rtl/alu_instr_sequencer_pkg.sv
// Shared definitions for the fetch/execute sequencer: ALU op codes, sequencer
// states, IR field positions and small op-classification helpers.
package alu_instr_sequencer_pkg;

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,
        OP_SUB  = 5'd1,
        OP_AND  = 5'd2,
        OP_OR   = 5'd3,
        OP_NOT  = 5'd4,
        OP_MUL  = 5'd5,
        OP_DIV  = 5'd6,
        OP_ROL  = 5'd7,
        OP_ROR  = 5'd8,
        OP_SHR  = 5'd9,
        OP_SHRA = 5'd10,
        OP_SHL  = 5'd11,
        OP_NEG  = 5'd12
    } alu_op_t;

    typedef enum logic [2:0] {
        IDLE, T0, T1, T2, T3, T4, T5, T6
    } seq_state_t;

    localparam int IR_OP_LSB = 27;
    localparam int IR_RA_LSB = 23;
    localparam int IR_RB_LSB = 19;
    localparam int IR_RC_LSB = 15;

    function automatic logic op_is_legal(input logic [4:0] op);
        return op <= OP_NEG;
    endfunction

    // Unary ops take their only operand from Rb, so T4 reuses Rb instead of Rc.
    function automatic logic op_is_unary(input logic [4:0] op);
        return (op == OP_NOT) || (op == OP_NEG);
    endfunction

    function automatic logic op_is_muldiv(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_instr_sequencer_reg_onehot_decode.sv
// 4-bit register index to one-hot select/enable vector, gated by en.
module reg_onehot_decode #(
    parameter int NUM_REGS = 16
) (
    input  logic [3:0]          sel,
    input  logic                en,
    output logic [NUM_REGS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            onehot[i] = en && (sel == 4'(i));
        end
    end

endmodule

// File: rtl/alu_instr_sequencer.sv
// Moore control unit stepping the datapath through fetch (T0..T2) and
// register-register ALU execute (T3..T6); outputs decode from state and IR.
module alu_instr_sequencer
    import alu_instr_sequencer_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int ALU_OP_W = 6
) (
    input  logic                w_clock,
    input  logic                w_clear,
    input  logic                run,
    input  logic                mem_ready,
    input  logic [31:0]         ir,
    output logic                s_PC,
    output logic                s_Zlow,
    output logic                s_Zhigh,
    output logic                s_MDR,
    output logic [NUM_REGS-1:0] s_R,
    output logic [NUM_REGS-1:0] e_R,
    output logic                e_MAR,
    output logic                e_PC,
    output logic                e_MDR,
    output logic                e_IR,
    output logic                e_Y,
    output logic                e_Z,
    output logic                e_HI,
    output logic                e_LO,
    output logic                w_IncPC,
    output logic                w_read,
    output logic                e_alu,
    output logic [ALU_OP_W-1:0] opcode,
    output logic                busy,
    output logic                done,
    output logic                illegal
);

    seq_state_t state;

    logic [4:0] op;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;
    logic       legal;
    logic       unary;
    logic       muldiv;
    logic       ir_unused;

    logic       sr_en;
    logic [3:0] sr_sel;
    logic       er_en;

    assign op        = ir[IR_OP_LSB +: 5];
    assign ra        = ir[IR_RA_LSB +: 4];
    assign rb        = ir[IR_RB_LSB +: 4];
    assign rc        = ir[IR_RC_LSB +: 4];
    assign ir_unused = ^ir[IR_RC_LSB-1:0];

    assign legal  = op_is_legal(op);
    assign unary  = op_is_unary(op);
    assign muldiv = op_is_muldiv(op);

    // Instruction end points (T3 illegal, T5, T6) restart a fetch only if run is still high.
    always_ff @(posedge w_clock or negedge w_clear) begin
        if (!w_clear) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (run) state <= T0;
                T0:      state <= T1;
                T1:      if (mem_ready) state <= T2;
                T2:      state <= T3;
                T3:      state <= legal ? T4 : (run ? T0 : IDLE);
                T4:      state <= T5;
                T5:      state <= muldiv ? T6 : (run ? T0 : IDLE);
                T6:      state <= run ? T0 : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        s_PC    = 1'b0;
        s_Zlow  = 1'b0;
        s_Zhigh = 1'b0;
        s_MDR   = 1'b0;
        e_MAR   = 1'b0;
        e_PC    = 1'b0;
        e_MDR   = 1'b0;
        e_IR    = 1'b0;
        e_Y     = 1'b0;
        e_Z     = 1'b0;
        e_HI    = 1'b0;
        e_LO    = 1'b0;
        w_IncPC = 1'b0;
        w_read  = 1'b0;
        e_alu   = 1'b0;
        opcode  = '0;
        done    = 1'b0;
        illegal = 1'b0;
        sr_en   = 1'b0;
        sr_sel  = rb;
        er_en   = 1'b0;
        case (state)
            T0: begin
                s_PC    = 1'b1;
                e_MAR   = 1'b1;
                w_IncPC = 1'b1;
                e_Z     = 1'b1;
            end
            T1: begin
                s_Zlow = 1'b1;
                e_PC   = 1'b1;
                w_read = 1'b1;
                e_MDR  = 1'b1;
            end
            T2: begin
                s_MDR = 1'b1;
                e_IR  = 1'b1;
            end
            T3: begin
                if (legal) begin
                    sr_en = 1'b1;
                    e_Y   = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            T4: begin
                e_alu  = 1'b1;
                e_Z    = 1'b1;
                opcode = ALU_OP_W'(op);
                sr_en  = 1'b1;
                if (!unary) sr_sel = rc;
            end
            T5: begin
                s_Zlow = 1'b1;
                if (muldiv) begin
                    e_LO = 1'b1;
                end else begin
                    er_en = 1'b1;
                    done  = 1'b1;
                end
            end
            T6: begin
                s_Zhigh = 1'b1;
                e_HI    = 1'b1;
                done    = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE);

    reg_onehot_decode #(.NUM_REGS(NUM_REGS)) u_s_r_decode (
        .sel    (sr_sel),
        .en     (sr_en),
        .onehot (s_R)
    );

    reg_onehot_decode #(.NUM_REGS(NUM_REGS)) u_e_r_decode (
        .sel    (ra),
        .en     (er_en),
        .onehot (e_R)
    );

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Bench for alu_instr_sequencer: directed instruction table, reset corner
// cases, then a random instruction stream checked against a per-cycle model.
module tb_alu_instr_sequencer;

    logic        w_clock = 1'b0;
    logic        w_clear;
    logic        run;
    logic        mem_ready;
    logic [31:0] ir;
    logic        s_PC, s_Zlow, s_Zhigh, s_MDR;
    logic [15:0] s_R, e_R;
    logic        e_MAR, e_PC, e_MDR, e_IR, e_Y, e_Z, e_HI, e_LO;
    logic        w_IncPC, w_read, e_alu;
    logic [5:0]  opcode;
    logic        busy, done, illegal;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        s_pc, s_zlow, s_zhigh, s_mdr;
        logic [15:0] s_r, e_r;
        logic        e_mar, e_pc, e_mdr, e_ir, e_y, e_z, e_hi, e_lo;
        logic        inc_pc, rd, e_alu;
        logic [5:0]  opc;
        logic        busy, done, illegal;
    } outs_t;

    typedef struct {
        logic [31:0] ir;
        int          nwait;
        bit          run_after;
        int          kind;
        int          cycles;
        logic [15:0] sr_t3;
        logic [15:0] sr_t4;
        logic [15:0] er_t5;
        int          opc;
        string       name;
    } vec_t;

    typedef struct {
        outs_t       exp;
        logic [31:0] ir;
        logic        run;
        logic        mem_ready;
    } step_t;

    vec_t  vecs[6];
    step_t sched[$];

    alu_instr_sequencer #(.NUM_REGS(16), .ALU_OP_W(6)) dut (
        .w_clock   (w_clock),
        .w_clear   (w_clear),
        .run       (run),
        .mem_ready (mem_ready),
        .ir        (ir),
        .s_PC      (s_PC),
        .s_Zlow    (s_Zlow),
        .s_Zhigh   (s_Zhigh),
        .s_MDR     (s_MDR),
        .s_R       (s_R),
        .e_R       (e_R),
        .e_MAR     (e_MAR),
        .e_PC      (e_PC),
        .e_MDR     (e_MDR),
        .e_IR      (e_IR),
        .e_Y       (e_Y),
        .e_Z       (e_Z),
        .e_HI      (e_HI),
        .e_LO      (e_LO),
        .w_IncPC   (w_IncPC),
        .w_read    (w_read),
        .e_alu     (e_alu),
        .opcode    (opcode),
        .busy      (busy),
        .done      (done),
        .illegal   (illegal)
    );

    always #5 w_clock = ~w_clock;

    function automatic outs_t sample();
        outs_t s;
        s.s_pc = s_PC;     s.s_zlow = s_Zlow; s.s_zhigh = s_Zhigh; s.s_mdr = s_MDR;
        s.s_r = s_R;       s.e_r = e_R;
        s.e_mar = e_MAR;   s.e_pc = e_PC;     s.e_mdr = e_MDR;     s.e_ir = e_IR;
        s.e_y = e_Y;       s.e_z = e_Z;       s.e_hi = e_HI;       s.e_lo = e_LO;
        s.inc_pc = w_IncPC; s.rd = w_read;    s.e_alu = e_alu;
        s.opc = opcode;    s.busy = busy;     s.done = done;       s.illegal = illegal;
        return s;
    endfunction

    // Expected strobes for step k of an instruction (0 = first fetch cycle,
    // 6 = high-word write-back); negative k means the sequencer is idle.
    function automatic outs_t expect_phase(input int k, input logic [31:0] instr);
        outs_t e = '0;
        int op = int'(instr[31:27]);
        int ra = int'(instr[26:23]);
        int rb = int'(instr[22:19]);
        int rc = int'(instr[18:15]);
        if (k >= 0) e.busy = 1'b1;
        case (k)
            0: begin e.s_pc = 1; e.e_mar = 1; e.inc_pc = 1; e.e_z = 1; end
            1: begin e.s_zlow = 1; e.e_pc = 1; e.rd = 1; e.e_mdr = 1; end
            2: begin e.s_mdr = 1; e.e_ir = 1; end
            3: begin
                if (op > 12) e.illegal = 1;
                else begin e.s_r = 16'(1) << rb; e.e_y = 1; end
            end
            4: begin
                e.e_alu = 1; e.e_z = 1; e.opc = 6'(op);
                e.s_r = 16'(1) << ((op == 4 || op == 12) ? rb : rc);
            end
            5: begin
                e.s_zlow = 1;
                if (op == 5 || op == 6) e.e_lo = 1;
                else begin e.e_r = 16'(1) << ra; e.done = 1; end
            end
            6: begin e.s_zhigh = 1; e.e_hi = 1; e.done = 1; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic check_output(input string name, input outs_t act, input outs_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Starts from IDLE, runs one table instruction, records each busy cycle and
    // compares the recorded cycles with the table entry's hand-computed values.
    task automatic run_vector(input vec_t v);
        outs_t obs[40];
        outs_t s;
        outs_t ill;
        int    n = 0;
        bit    ended = 0;
        int    i3 = 3 + v.nwait;
        for (int i = 0; i < 40; i++) obs[i] = '0;
        ir = v.ir; run = 1'b1; mem_ready = 1'b0;
        @(posedge w_clock);
        while (!ended && n < 40) begin
            #1;
            mem_ready = (n >= 1 + v.nwait);
            run       = v.run_after;
            @(negedge w_clock);
            obs[n] = sample();
            ended  = obs[n].done | obs[n].illegal;
            n++;
            if (!ended) @(posedge w_clock);
        end
        check_val({v.name, " cycles"}, n, v.cycles);
        check_output({v.name, " T0"}, obs[0], expect_phase(0, v.ir));
        for (int k = 1; k <= 1 + v.nwait; k++)
            check_output($sformatf("%s T1 cycle %0d", v.name, k), obs[k], expect_phase(1, v.ir));
        check_output({v.name, " T2"}, obs[2 + v.nwait], expect_phase(2, v.ir));
        if (v.kind == 2) begin
            ill = '0; ill.busy = 1; ill.illegal = 1;
            check_output({v.name, " T3 illegal"}, obs[i3], ill);
        end else begin
            check_val({v.name, " T3 s_R"}, int'(obs[i3].s_r), int'(v.sr_t3));
            check_val({v.name, " T3 e_Y"}, int'(obs[i3].e_y), 1);
            check_val({v.name, " T4 s_R"}, int'(obs[i3+1].s_r), int'(v.sr_t4));
            check_val({v.name, " T4 opcode"}, int'(obs[i3+1].opc), v.opc);
            check_val({v.name, " T4 e_alu"}, int'(obs[i3+1].e_alu), 1);
            check_val({v.name, " T5 s_Zlow"}, int'(obs[i3+2].s_zlow), 1);
            check_val({v.name, " T5 e_R"}, int'(obs[i3+2].e_r), int'(v.er_t5));
            if (v.kind == 1) begin
                check_val({v.name, " T5 e_LO"}, int'(obs[i3+2].e_lo), 1);
                check_val({v.name, " T5 done"}, int'(obs[i3+2].done), 0);
                check_val({v.name, " T6 zhigh/hi/done"},
                          int'({obs[i3+3].s_zhigh, obs[i3+3].e_hi, obs[i3+3].done}), 7);
                check_val({v.name, " T6 e_R"}, int'(obs[i3+3].e_r), 0);
            end else begin
                check_val({v.name, " T5 done"}, int'(obs[i3+2].done), 1);
            end
        end
        @(posedge w_clock);
        #1;
        @(negedge w_clock);
        s = sample();
        if (v.run_after) begin
            check_output({v.name, " next is T0"}, s, expect_phase(0, v.ir));
            run = 1'b0; mem_ready = 1'b1;
            for (int k = 0; k < 20 && busy; k++) @(negedge w_clock);
            check_val({v.name, " drain to idle"}, int'(busy), 0);
        end else begin
            check_output({v.name, " back to idle"}, s, '0);
        end
    endtask

    task automatic push_step(input int k, input logic [31:0] instr, input logic run_v,
                             input logic mr_v);
        step_t st;
        st.exp       = expect_phase(k, instr);
        st.ir        = (k >= 3) ? instr : $urandom;
        st.run       = run_v;
        st.mem_ready = mr_v;
        sched.push_back(st);
    endtask

    // Random instruction stream: idle gaps of 0..2 cycles (0 = back-to-back),
    // random mem wait states, random run level on cycles that do not decide.
    task automatic build_random(input int n_instr);
        int gaps[64];
        for (int j = 0; j < n_instr; j++)
            gaps[j] = (j == 0) ? int'($urandom_range(1, 2)) : int'($urandom_range(0, 2));
        for (int j = 0; j < n_instr; j++) begin
            logic [31:0] instr;
            int op, nw, last_k;
            logic last_run;
            for (int g = 0; g < gaps[j]; g++)
                push_step(-1, 32'h0, (g == gaps[j] - 1), 1'($urandom));
            op = ($urandom_range(0, 4) == 0) ? int'($urandom_range(13, 31))
                                             : int'($urandom_range(0, 12));
            instr = $urandom;
            instr[31:27] = 5'(op);
            nw = int'($urandom_range(0, 3));
            last_run = (j + 1 < n_instr) && (gaps[j + 1] == 0);
            last_k = (op > 12) ? 3 : ((op == 5 || op == 6) ? 6 : 5);
            push_step(0, instr, 1'($urandom), 1'($urandom));
            for (int w = 0; w <= nw; w++)
                push_step(1, instr, 1'($urandom), (w == nw));
            for (int k = 2; k <= last_k; k++)
                push_step(k, instr, (k == last_k) ? last_run : 1'($urandom), 1'($urandom));
        end
        for (int g = 0; g < 3; g++) push_step(-1, 32'h0, 1'b0, 1'($urandom));
    endtask

    task automatic apply_stimulus();
        for (int i = 0; i < sched.size(); i++) begin
            @(posedge w_clock);
            #1;
            ir        = sched[i].ir;
            run       = sched[i].run;
            mem_ready = sched[i].mem_ready;
            @(negedge w_clock);
            check_output($sformatf("rand step %0d", i), sample(), sched[i].exp);
        end
    endtask

    initial begin
        vecs[0] = '{32'h18918000, 0, 1'b0, 0, 6, 16'h0004, 16'h0008, 16'h0002, 3,  "or R1,R2,R3"};
        vecs[1] = '{32'h2A2B0000, 0, 1'b0, 1, 7, 16'h0020, 16'h0040, 16'h0000, 5,  "mul R4,R5,R6"};
        vecs[2] = '{32'h63C00000, 0, 1'b0, 0, 6, 16'h0100, 16'h0100, 16'h0080, 12, "neg R7,R8"};
        vecs[3] = '{32'h007C8000, 3, 1'b0, 0, 9, 16'h8000, 16'h0200, 16'h0001, 0,  "add R0 wait3"};
        vecs[4] = '{32'hA0918000, 0, 1'b1, 2, 4, 16'h0000, 16'h0000, 16'h0000, 0,  "illegal op20"};
        vecs[5] = '{32'h311A0000, 1, 1'b0, 1, 8, 16'h0008, 16'h0010, 16'h0000, 6,  "div R2 wait1"};

        w_clear = 1'b0; run = 1'b1; mem_ready = 1'b1; ir = $urandom;
        repeat (3) @(negedge w_clock);
        check_output("reset hold", sample(), '0);
        w_clear = 1'b1;
        #1;
        check_output("released before edge", sample(), '0);
        @(negedge w_clock);
        check_output("first fetch T0", sample(), expect_phase(0, ir));
        #1;
        w_clear = 1'b0; run = 1'b0;
        #1;
        check_output("clear during T0", sample(), '0);
        @(negedge w_clock);
        w_clear = 1'b1;

        for (int i = 0; i < 6; i++) run_vector(vecs[i]);

        ir = 32'h18918000; run = 1'b1; mem_ready = 1'b1;
        repeat (5) @(posedge w_clock);
        @(negedge w_clock);
        check_val("pre-clear e_alu in T4", int'(e_alu), 1);
        #1;
        w_clear = 1'b0; run = 1'b0;
        #1;
        check_output("async clear in T4", sample(), '0);
        @(posedge w_clock);
        #1;
        w_clear = 1'b1;
        @(negedge w_clock);
        check_output("idle after clear", sample(), '0);

        build_random(40);
        apply_stimulus();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
